// File: rtl/pdh_pkg.sv
// ----------------------------------------------------------------------------
// pdh_pkg
// Shared definitions for the DAC streaming sink: converter width, the
// midscale code, the sink state machine encoding, the sample pair layout and
// the two's-complement to offset-binary conversion used on the output path.
// No ports (package).
// ----------------------------------------------------------------------------
package pdh_pkg;

    localparam int DAC_WIDTH  = 14;
    localparam int AXIS_WIDTH = 32;
    localparam int CH_B_LSB   = 16;

    localparam logic [DAC_WIDTH-1:0] DAC_MIDSCALE = 14'h2000;

    typedef enum logic [1:0] {
        HOLD_RST = 2'd0,
        IDLE     = 2'd1,
        RUN      = 2'd2
    } dacState_t;

    typedef struct packed {
        logic [DAC_WIDTH-1:0] chB;
        logic [DAC_WIDTH-1:0] chA;
    } samplePair_t;

    // Offset binary is the two's-complement code with its sign bit flipped,
    // so the most negative value maps to 0 and zero maps to midscale.
    function automatic logic [DAC_WIDTH-1:0] toOffsetBinary(input logic [DAC_WIDTH-1:0] value);
        return {~value[DAC_WIDTH-1], value[DAC_WIDTH-2:0]};
    endfunction

endpackage

// File: rtl/dac_axis_sink_if.sv
// ----------------------------------------------------------------------------
// dac_axis_sink_if
// AXI-Stream style sample-pair channel feeding the DAC sink.
//   tdata  : sample pair, channel A in the low lane, channel B in the high lane
//   tvalid : upstream has a pair on tdata
//   tready : sink can take the pair this cycle
// master drives tdata/tvalid, slave drives tready.
// ----------------------------------------------------------------------------
interface dac_axis_sink_if;
    import pdh_pkg::*;

    logic [AXIS_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/dac_axis_sink.sv
// ----------------------------------------------------------------------------
// dac_axis_sink
// Takes two's-complement sample pairs from a stream and plays them out to an
// interleaved two-channel DAC, one channel per clock (A then B). Holds the DAC
// in reset for RST_CYCLES after reset release, then drives midscale while
// disabled. When no new pair is ready at a frame boundary the previous pair is
// repeated and an underflow counter is bumped.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   s_axis           : sample-pair stream (slave side)
//   enable_i         : stream to the DAC when high, midscale when low
//   clr_i            : synchronous clear of the underflow counter
//   dac_dat_o        : DAC data, offset binary
//   dac_sel_o        : channel select, 1 = A, 0 = B
//   dac_wrt_o        : DAC write strobe
//   dac_rst_o        : DAC reset
//   underflow_cnt_o  : saturating count of frames with no fresh pair
//   running_o        : state machine is streaming
// ----------------------------------------------------------------------------
module dac_axis_sink
    import pdh_pkg::*;
#(
    parameter int RST_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    dac_axis_sink_if.slave       s_axis,
    input  logic                 enable_i,
    input  logic                 clr_i,
    output logic [DAC_WIDTH-1:0] dac_dat_o,
    output logic                 dac_sel_o,
    output logic                 dac_wrt_o,
    output logic                 dac_rst_o,
    output logic [15:0]          underflow_cnt_o,
    output logic                 running_o
);

    localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);

    dacState_t            r_state;
    dacState_t            w_stateNext;
    logic [CNT_W-1:0]     r_rstCnt;
    logic                 r_phase;
    logic                 w_phaseNext;
    samplePair_t          r_hold;
    samplePair_t          r_cur;
    samplePair_t          w_inPair;
    logic                 r_holdVld;
    logic                 w_holdVldNext;
    logic                 r_tready;
    logic                 w_treadyNext;
    logic [15:0]          r_underflowCnt;
    logic                 w_consume;
    logic                 w_accept;
    logic                 w_leaveRun;
    logic                 w_underflow;
    logic [DAC_WIDTH-1:0] r_dat;
    logic                 r_sel;
    logic                 r_wrt;
    logic                 r_rst;
    logic                 r_running;
    logic [DAC_WIDTH-1:0] w_datNext;
    logic                 w_selNext;
    logic                 w_wrtNext;
    logic                 w_rstNext;
    logic                 w_runningNext;
    logic                 w_unusedBits;

    assign w_inPair     = {s_axis.tdata[CH_B_LSB +: DAC_WIDTH], s_axis.tdata[DAC_WIDTH-1:0]};
    assign w_unusedBits = ^{s_axis.tdata[AXIS_WIDTH-1:CH_B_LSB+DAC_WIDTH],
                            s_axis.tdata[CH_B_LSB-1:DAC_WIDTH]};

    // A frame ends on the B cycle; that is the only point where a new pair
    // moves into the frame register and where enable_i is looked at, so a
    // disable never cuts a frame in half.
    assign w_consume   = (r_state == RUN) && r_phase;
    assign w_accept    = s_axis.tvalid && r_tready;
    assign w_leaveRun  = w_consume && !enable_i;
    assign w_underflow = w_consume && enable_i && !r_holdVld;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= HOLD_RST;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Reset-hold timer; only runs while the DAC is held in reset and restarts
    // from zero every time that state is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstCnt <= '0;
        end else if (r_state == HOLD_RST) begin
            r_rstCnt <= r_rstCnt + CNT_W'(1);
        end else begin
            r_rstCnt <= '0;
        end
    end

    // Next-state logic: fixed-length reset hold, wait for enable, then
    // stream until enable is seen low at the end of a frame.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            HOLD_RST: if (r_rstCnt == RST_LAST) w_stateNext = IDLE;
            IDLE:     if (enable_i) w_stateNext = RUN;
            RUN:      if (w_leaveRun) w_stateNext = IDLE;
            default:  w_stateNext = HOLD_RST;
        endcase
    end

    // Next values of the phase, holding-register flag and tready. tready is
    // registered, so it is computed from the values the other registers are
    // about to take; the holding register can take a new pair on the same
    // cycle it hands its old one to the frame register.
    always_comb begin
        w_phaseNext = (r_state == RUN) && (w_stateNext == RUN) && !r_phase;
        if ((r_state != RUN) || w_leaveRun) begin
            w_holdVldNext = 1'b0;
        end else if (w_accept) begin
            w_holdVldNext = 1'b1;
        end else if (w_consume) begin
            w_holdVldNext = 1'b0;
        end else begin
            w_holdVldNext = r_holdVld;
        end
        w_treadyNext = (w_stateNext == RUN) && (!w_holdVldNext || w_phaseNext);
    end

    // Holding and frame registers. Leaving RUN throws away anything buffered
    // so the next run starts from a clean zero frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold    <= '0;
            r_cur     <= '0;
            r_holdVld <= 1'b0;
            r_phase   <= 1'b0;
            r_tready  <= 1'b0;
        end else begin
            r_phase   <= w_phaseNext;
            r_holdVld <= w_holdVldNext;
            r_tready  <= w_treadyNext;
            if (w_accept && !w_leaveRun) begin
                r_hold <= w_inPair;
            end
            if (w_leaveRun) begin
                r_cur <= '0;
            end else if (w_consume && r_holdVld) begin
                r_cur <= r_hold;
            end
        end
    end

    // Underflow counter: clear wins over increment, and it sticks at all-ones
    // rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underflowCnt <= '0;
        end else if (clr_i) begin
            r_underflowCnt <= '0;
        end else if (w_underflow && (r_underflowCnt != 16'hFFFF)) begin
            r_underflowCnt <= r_underflowCnt + 16'd1;
        end
    end

    // Output decode. Status outputs follow the state being entered so they
    // line up with the state itself; the data path plays out the channel of
    // the current phase from the frame register.
    always_comb begin
        w_datNext     = DAC_MIDSCALE;
        w_selNext     = 1'b1;
        w_wrtNext     = (w_stateNext != HOLD_RST);
        w_rstNext     = (w_stateNext == HOLD_RST);
        w_runningNext = (w_stateNext == RUN);
        case (r_state)
            IDLE: begin
                w_selNext = ~r_sel;
            end
            RUN: begin
                if (r_phase) begin
                    w_datNext = toOffsetBinary(r_cur.chB);
                    w_selNext = 1'b0;
                end else begin
                    w_datNext = toOffsetBinary(r_cur.chA);
                    w_selNext = 1'b1;
                end
            end
            default: begin
                w_selNext = 1'b1;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dat     <= DAC_MIDSCALE;
            r_sel     <= 1'b1;
            r_wrt     <= 1'b0;
            r_rst     <= 1'b1;
            r_running <= 1'b0;
        end else begin
            r_dat     <= w_datNext;
            r_sel     <= w_selNext;
            r_wrt     <= w_wrtNext;
            r_rst     <= w_rstNext;
            r_running <= w_runningNext;
        end
    end

    assign dac_dat_o       = r_dat;
    assign dac_sel_o       = r_sel;
    assign dac_wrt_o       = r_wrt;
    assign dac_rst_o       = r_rst;
    assign running_o       = r_running;
    assign underflow_cnt_o = r_underflowCnt;
    assign s_axis.tready   = r_tready;

endmodule

// File: tb/tb_dac_axis_sink.sv
// ----------------------------------------------------------------------------
// tb_dac_axis_sink
// Drives the DAC sink through reset, idle, streaming, underflow, disable and
// mid-run reset, and compares every output each cycle against a frame-level
// reference model.
// ----------------------------------------------------------------------------
module tb_dac_axis_sink;

    localparam int          RST_CYCLES = 16;
    localparam logic [13:0] MID        = 14'h2000;
    localparam int          M_HOLD     = 0;
    localparam int          M_IDLE     = 1;
    localparam int          M_RUN      = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_i;
    logic        clr_i;
    logic [13:0] dac_dat_o;
    logic        dac_sel_o;
    logic        dac_wrt_o;
    logic        dac_rst_o;
    logic [15:0] underflow_cnt_o;
    logic        running_o;

    dac_axis_sink_if axisBus();

    dac_axis_sink #(.RST_CYCLES(RST_CYCLES)) dut (
        .clk             (clk),
        .rst             (rst),
        .s_axis          (axisBus),
        .enable_i        (enable_i),
        .clr_i           (clr_i),
        .dac_dat_o       (dac_dat_o),
        .dac_sel_o       (dac_sel_o),
        .dac_wrt_o       (dac_wrt_o),
        .dac_rst_o       (dac_rst_o),
        .underflow_cnt_o (underflow_cnt_o),
        .running_o       (running_o)
    );

    always #5 clk = ~clk;

    int nAsserts = 0;
    int nFails   = 0;

    // Reference model: mode, cycles of reset hold left, which half of the
    // frame the coming cycle is, a one-deep buffer queue, the pair being
    // played, the underflow tally and the expected output values.
    int          mMode;
    int          mRstLeft;
    int          mPhase;
    logic [27:0] holdQ[$];
    logic [27:0] mCur;
    int          mUcnt;
    logic [13:0] mDat;
    logic        mSel;
    bit          lastAccept;

    // Two's-complement code to offset binary through plain signed arithmetic.
    function automatic logic [13:0] toOffset(input logic [13:0] v);
        int s;
        s = (int'(v) >= 8192) ? int'(v) - 16384 : int'(v);
        return 14'(s + 8192);
    endfunction

    function automatic bit modelReady();
        return (mMode == M_RUN) && ((holdQ.size() == 0) || (mPhase == 1));
    endfunction

    task automatic modelReset();
        mMode    = M_HOLD;
        mRstLeft = RST_CYCLES;
        mPhase   = 0;
        holdQ.delete();
        mCur     = '0;
        mUcnt    = 0;
        mDat     = MID;
        mSel     = 1'b1;
    endtask

    // One clock edge of the reference model, using the inputs seen at it.
    task automatic modelEdge(input bit valid, input logic [31:0] data, input bit en, input bit clr);
        logic [27:0] pair;
        bit          acc;
        pair       = {data[29:16], data[13:0]};
        acc        = valid && modelReady();
        lastAccept = acc;
        case (mMode)
            M_HOLD: begin
                mDat = MID;
                mSel = 1'b1;
                mRstLeft--;
                if (mRstLeft == 0) mMode = M_IDLE;
            end
            M_IDLE: begin
                mDat = MID;
                mSel = !mSel;
                if (en) begin
                    mMode  = M_RUN;
                    mPhase = 0;
                end
            end
            default: begin
                if (mPhase == 0) begin
                    mDat = toOffset(mCur[13:0]);
                    mSel = 1'b1;
                    if (acc) holdQ.push_back(pair);
                    mPhase = 1;
                end else begin
                    mDat = toOffset(mCur[27:14]);
                    mSel = 1'b0;
                    if (!en) begin
                        holdQ.delete();
                        mCur   = '0;
                        mMode  = M_IDLE;
                        mPhase = 0;
                    end else begin
                        if (holdQ.size() > 0) mCur = holdQ.pop_front();
                        else if (mUcnt < 65535) mUcnt++;
                        if (acc) holdQ.push_back(pair);
                        mPhase = 0;
                    end
                end
            end
        endcase
        if (clr) mUcnt = 0;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Compare every DUT output with the model after an edge.
    task automatic checkOutput();
        checkVal("dac_dat",   32'(dac_dat_o),       32'(mDat));
        checkVal("dac_sel",   32'(dac_sel_o),       32'(mSel));
        checkVal("dac_wrt",   32'(dac_wrt_o),       32'(mMode != M_HOLD));
        checkVal("dac_rst",   32'(dac_rst_o),       32'(mMode == M_HOLD));
        checkVal("tready",    32'(axisBus.tready),  32'(modelReady()));
        checkVal("underflow", 32'(underflow_cnt_o), 32'(mUcnt));
        checkVal("running",   32'(running_o),       32'(mMode == M_RUN));
    endtask

    // Outputs while reset is asserted.
    task automatic checkReset();
        checkVal("rst_dat",     32'(dac_dat_o),       32'(MID));
        checkVal("rst_sel",     32'(dac_sel_o),       32'd1);
        checkVal("rst_wrt",     32'(dac_wrt_o),       32'd0);
        checkVal("rst_dacrst",  32'(dac_rst_o),       32'd1);
        checkVal("rst_tready",  32'(axisBus.tready),  32'd0);
        checkVal("rst_ucnt",    32'(underflow_cnt_o), 32'd0);
        checkVal("rst_running", 32'(running_o),       32'd0);
    endtask

    task automatic applyStimulus(input bit valid, input logic [31:0] data, input bit en, input bit clr);
        axisBus.tvalid = valid;
        axisBus.tdata  = data;
        enable_i       = en;
        clr_i          = clr;
        @(posedge clk);
        modelEdge(valid, data, en, clr);
        #1;
        checkOutput();
    endtask

    // Assert reset between edges, check its effect without waiting for a
    // clock, then release it just after an edge.
    task automatic doReset();
        #3;
        rst = 1'b1;
        #1;
        checkReset();
        @(posedge clk);
        #1;
        checkReset();
        rst = 1'b0;
        modelReset();
    endtask

    function automatic logic [31:0] pairWord(input logic [13:0] a, input logic [13:0] b);
        logic [31:0] w;
        w = $urandom();
        w[13:0]  = a;
        w[29:16] = b;
        return w;
    endfunction

    initial begin
        logic [31:0] firstPairs[2];
        int          idx;
        int          budget;

        rst            = 1'b0;
        axisBus.tvalid = 1'b0;
        axisBus.tdata  = '0;
        enable_i       = 1'b0;
        clr_i          = 1'b0;
        lastAccept     = 1'b0;
        modelReset();

        $display("[TB] reset and idle");
        doReset();
        for (int i = 0; i < 22; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);

        $display("[TB] streaming with known pairs");
        firstPairs[0] = pairWord(14'h1FFF, 14'h2000);
        firstPairs[1] = pairWord(14'h0001, 14'h3FFF);
        idx = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, (idx < 2) ? firstPairs[idx] : $urandom(), 1'b1, 1'b0);
            if (lastAccept) idx++;
        end

        $display("[TB] underflow and clear");
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, $urandom(), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, $urandom(), 1'b1, 1'b0);
        applyStimulus(1'b1, $urandom(), 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, $urandom(), 1'b1, 1'b0);

        $display("[TB] incrementing sequence with random gaps");
        idx    = 0;
        budget = 0;
        while ((idx < 100) && (budget < 1000)) begin
            applyStimulus(($urandom_range(3, 0) != 0), pairWord(14'(idx), 14'(idx + 256)), 1'b1, 1'b0);
            if (lastAccept) idx++;
            budget++;
        end
        checkVal("seq_complete", 32'(idx), 32'd100);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, $urandom(), 1'b1, 1'b0);

        $display("[TB] disable during channel A");
        budget = 0;
        while (!((mMode == M_RUN) && (mPhase == 0)) && (budget < 4)) begin
            applyStimulus(1'b1, $urandom(), 1'b1, 1'b0);
            budget++;
        end
        checkVal("phase_align", 32'(mPhase), 32'd0);
        applyStimulus(1'b1, $urandom(), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, $urandom(), 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) applyStimulus($urandom_range(1, 0) == 1, $urandom(), 1'b1, 1'b0);

        $display("[TB] reset during streaming");
        doReset();
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, $urandom(), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, $urandom(), 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/dac_axis_sink.md
DAC_AXIS_SINK -- requirements
Module: dac_axis_sink

Interface
REQ-001 RST_CYCLES, default 16, number of cycles dac_rst_o is held high after reset release.
REQ-002 DAC_WIDTH, default 14, DAC converter data width; taken from the shared package.
REQ-003 clk  input  1  Single clock for all logic; every output is registered on its rising edge.
REQ-004 rst  input  1  Asynchronous, active-high reset.
REQ-005 s_axis_tdata  input  32  Sample pair in two's complement: [13:0] = channel A, [29:16] = channel B; other bits ignored.
REQ-006 s_axis_tvalid  input  1  Upstream sample pair is valid.
REQ-007 s_axis_tready  output  1  The sink accepts a pair on any cycle where tvalid and tready are both high.
REQ-008 enable_i  input  1  High = stream to the DAC; low = drive midscale.
REQ-009 clr_i  input  1  Synchronous clear of the underflow counter.
REQ-010 dac_dat_o  output  14  DAC data in offset binary.
REQ-011 dac_sel_o  output  1  Channel select: 1 = channel A, 0 = channel B.
REQ-012 dac_wrt_o  output  1  Write strobe.
REQ-013 dac_rst_o  output  1  DAC reset.
REQ-014 underflow_cnt_o  output  16  Saturating count of frames for which no new pair was available.
REQ-015 running_o  output  1  High while the state machine is in RUN.

Function
REQ-016 FSM states: HOLD_RST, IDLE, RUN.
REQ-017 HOLD_RST: dac_rst_o=1 for exactly RST_CYCLES cycles, then go to IDLE.
REQ-018 IDLE: go to RUN on the cycle enable_i is sampled high; the first RUN cycle has phase=0.
REQ-019 RUN: phase toggles every cycle; a frame is one phase=0 cycle (A) followed by one phase=1 cycle (B).
REQ-020 Output register, RUN: phase=0 loads A(cur) with sel=1; phase=1 loads B(cur) with sel=0.
REQ-021 dac_wrt_o = 1 on every RUN and IDLE cycle, 0 in HOLD_RST.
REQ-022 Conversion: offset binary = two's complement value with the MSB inverted (0x0000 -> 0x2000, 0x1FFF -> 0x3FFF, 0x2000 -> 0x0000).
REQ-023 Buffering: one holding register (hold, hold_vld) feeds frame register cur.
REQ-024 consume = RUN and phase=1.
REQ-025 On consume with hold_vld=1: cur <= hold, hold_vld cleared unless a new pair is accepted in the same cycle.
REQ-026 On consume with hold_vld=0: cur retains the previous pair; underflow_cnt increments, saturating at 0xFFFF.
REQ-027 s_axis_tready = RUN and (hold_vld=0 or consume); a handshake coinciding with consume loads hold and keeps hold_vld=1.
REQ-028 Latency: a pair accepted at cycle t with hold empty appears as channel A on dac_dat_o at the first phase=0 edge after the next consume.
REQ-029 enable_i is sampled only at consume; if low, RUN -> IDLE after channel B completes (no truncated frame).
REQ-030 On RUN -> IDLE: hold_vld is flushed, cur is reset to 0, and the underflow counter does not count.
REQ-031 IDLE: dac_dat_o=0x2000, sel toggles each cycle, s_axis_tready=0.
REQ-032 clr_i has priority over increment: when both occur in the same cycle, the counter is 0.
REQ-033 running_o = (state == RUN).

Reset
REQ-034 rst asynchronously forces state=HOLD_RST, with reset counter=0.
REQ-035 rst forces dac_rst_o=1, dac_wrt_o=0, dac_dat_o=0x2000, dac_sel_o=1.
REQ-036 rst forces s_axis_tready=0, hold_vld=0, cur=0, underflow_cnt_o=0, phase=0, running_o=0.
REQ-037 Reset asserted mid-frame aborts immediately; there is no drain.

Structure
REQ-038 pdh_pkg holds: DAC_WIDTH, the midscale constant 0x2000, the FSM state enum, and a two's-complement-to-offset-binary function.
REQ-039 There are no sub-modules; the holding register is implemented inline.

Verification
REQ-040 Reset release with enable_i=0 -> dac_rst_o high for exactly 16 cycles, then dac_wrt_o=1 and dac_dat_o=0x2000 held.
REQ-041 enable_i=1 with continuous tvalid and pairs (A=0x1FFF, B=0x2000), then (0x0001, 0x3FFF) -> dac_dat_o shows 0x3FFF, 0x0000, then 0x2001, 0x1FFF, with sel 1,0,1,0; underflow count stays 0.
REQ-042 tvalid dropped for 3 frames -> the last pair repeats 3 times, underflow_cnt_o=3; after clr_i, the count is 0.
REQ-043 Handshake coinciding with consume -> no pair is lost or duplicated across a 100-pair incrementing sequence.
REQ-044 enable_i dropped during phase=0 -> channel B still output, then IDLE midscale; s_axis_tready low; hold flushed.
REQ-045 rst asserted mid-RUN -> all outputs take their reset values asynchronously, and the 16-cycle dac_rst_o sequence restarts.
